soc_bus_fabric: RTL
===================

# soc_bus_fabric

Parametrised single-initiator, multi-target bus fabric that replaces the point-to-point broadcast of `req_valid`/`addr`/`we`/`wrt_data` between the CPU core, memory and UART. It decodes the top address bits to select one of `NUM_TGT` targets and forwards one request at a time. It muxes and registers the selected target's response back to the core. Unmapped regions and, optionally, non-responding targets complete with an error response instead of hanging the core.

## Interface
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 32, address bus width
- `SEL_BITS`, 3, number of top address bits used for target decode
- `NUM_TGT`, 3, number of attached targets; must be ≥1 and ≤ 2^`SEL_BITS`
- `TIMEOUT`, 255, maximum response wait in cycles; must be ≥1
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-low reset
- `req_valid` in 1: initiator request strobe
- `addr` in `ADDR_WIDTH`: initiator address
- `we` in 1: 1 = write, 0 = read
- `wrt_data` in `DATA_WIDTH`: initiator write data
- `rd_data` out `DATA_WIDTH`: response data, registered
- `data_valid` out 1: one-cycle response pulse, registered
- `err` out 1: qualifies `data_valid`; 1 = unmapped or timed out
- `busy` out 1: transaction outstanding; requests are ignored while high
- `tgt_req_valid` out `NUM_TGT`: one-hot, one-cycle request pulse per target
- `tgt_addr` out `ADDR_WIDTH`: latched address, shared by all targets
- `tgt_we` out 1: latched write enable, shared
- `tgt_wrt_data` out `DATA_WIDTH`: latched write data, shared
- `tgt_rd_data` in `NUM_TGT*DATA_WIDTH`: target read data; target i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `tgt_data_valid` in `NUM_TGT`: per-target response strobe

## Operation
- State machine: IDLE, ISSUE, WAIT.
- IDLE with `req_valid`=1:
  - Latch `addr`, `we` and `wrt_data` into the `tgt_*` registers.
  - Set `sel` = `addr[ADDR_WIDTH-1 -: SEL_BITS]`.
  - If `sel` < `NUM_TGT`, go to ISSUE.
  - Otherwise the address is unmapped: stay in IDLE and produce an error response; no target is requested.
- ISSUE (exactly one cycle): `tgt_req_valid[sel]`=1, then go to WAIT. `tgt_data_valid[sel]` is already sampled in this cycle.
- WAIT: hold until `tgt_data_valid[sel]`=1, or until timeout when `BUS_TIMEOUT_EN` is defined.
- Normal completion: register `rd_data` ← `tgt_rd_data` slice `sel`, with `data_valid`=1 and `err`=0; return to IDLE.
  - Writes complete the same way; `rd_data` carries whatever the target drives.
- Error completion: `rd_data` = all ones, `data_valid`=1, `err`=1.
- `tgt_data_valid` from a non-selected target, or arriving while in IDLE, is ignored.
- `busy` = (state != IDLE).
- `req_valid` is ignored while `busy`=1; the initiator must hold off until it sees `data_valid`.
- `tgt_addr`, `tgt_we` and `tgt_wrt_data` stay stable from ISSUE until the next accepted request.

## Timing
- Reset values:
  - state IDLE
  - `rd_data`=0, `data_valid`=0, `err`=0, `busy`=0
  - `tgt_req_valid`=0, `tgt_addr`=0, `tgt_we`=0, `tgt_wrt_data`=0
  - timeout counter 0
- Reset mid-transaction aborts it with no response pulse. A late `tgt_data_valid` after reset is ignored.
- Mapped request sampled in cycle 0:
  - `tgt_req_valid` is high in cycle 1.
  - A target response in cycle k (k≥1) gives `data_valid` in cycle k+1.
  - Minimum latency is 2 cycles.
- Unmapped request sampled in cycle 0: `data_valid`=`err`=1 in cycle 1.
- Back-to-back: the cycle that carries `data_valid` is in IDLE, so a new `req_valid` is accepted in that same cycle.
- Timeout:
  - If no response arrives in cycles 1..`TIMEOUT`, the error response appears in cycle `TIMEOUT`+1.
  - A response arriving in cycle `TIMEOUT` completes normally.
  - A response in cycle `TIMEOUT` wins over expiry.
- Counter width is $clog2(`TIMEOUT`+1). It clears on ISSUE and never wraps.

## Configuration
- `BUS_TIMEOUT_EN` defined: timeout counter is present and a transaction that reaches `TIMEOUT` completes with an error as specified.
- `BUS_TIMEOUT_EN` undefined: no counter is built and WAIT holds indefinitely. `err` is then asserted only for unmapped addresses.

## Test plan
- Read, target 1 responds in cycle 1: `req_valid` with `addr`=0x2000_0010, `tgt_rd_data[1]`=0xCAFE_F00D → `tgt_req_valid`=3'b010 in cycle 1; `data_valid`=1, `rd_data`=0xCAFE_F00D, `err`=0 in cycle 2.
- Write to target 0 with a 5-cycle target delay: `addr`=0x0000_0004, `wrt_data`=0x1234_5678 →
  - `tgt_we`=1 and `tgt_wrt_data`=0x1234_5678 stable through WAIT.
  - `data_valid` in cycle 6.
  - A second `req_valid` in cycle 3 is ignored.
- Unmapped: `addr`=0xE000_0000 → no `tgt_req_valid`; `data_valid`=`err`=1 and `rd_data`=0xFFFF_FFFF in cycle 1.
- Timeout (`BUS_TIMEOUT_EN`, `TIMEOUT`=8): target 2 never responds → error response in cycle 9. Repeat with the response in cycle 8 → normal response in cycle 9, `err`=0.
- Stray strobe and back-to-back: `tgt_data_valid[0]` pulses while target 2 is selected → ignored. A new request issued in the same cycle as `data_valid` → accepted, with `tgt_req_valid` asserted on the next cycle.
- Reset asserted in WAIT → all outputs 0 immediately. A `tgt_data_valid` arriving after reset release produces no `data_valid`.

Source files
------------

// File: rtl/soc_bus_fabric.sv
// -----------------------------------------------------------------------------
// soc_bus_fabric
//
// Single-initiator, multi-target bus fabric. The core issues one request at a
// time. The top SEL_BITS address bits pick one of NUM_TGT targets, and the
// request is forwarded to that target as a one-cycle strobe. Address, write
// enable and write data are latched and shared by all targets. The selected
// target's response is muxed and registered back to the core. An unmapped
// address completes at once with an error response (rd_data all ones, err=1).
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   - a wait counter aborts a transaction with an error response
//               when the target stays silent for TIMEOUT cycles.
//   undefined - no counter is built and the fabric waits indefinitely.
//
// Ports
//   clk            : single clock
//   reset          : asynchronous, active-low reset
//   req_valid      : initiator request strobe (ignored while busy)
//   addr/we/wrt_data : initiator address, write enable, write data
//   rd_data        : registered response data
//   data_valid     : registered one-cycle response pulse
//   err            : qualifies data_valid; unmapped or timed out
//   busy           : transaction outstanding
//   tgt_req_valid  : one-hot, one-cycle request pulse per target
//   tgt_addr/tgt_we/tgt_wrt_data : latched request, shared by all targets
//   tgt_rd_data    : packed target read data; target i at [i*DATA_WIDTH +: DATA_WIDTH]
//   tgt_data_valid : per-target response strobe
// -----------------------------------------------------------------------------
module soc_bus_fabric #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_BITS   = 3,
    parameter int NUM_TGT    = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic                          we,
    input  logic [DATA_WIDTH-1:0]         wrt_data,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          data_valid,
    output logic                          err,
    output logic                          busy,
    output logic [NUM_TGT-1:0]            tgt_req_valid,
    output logic [ADDR_WIDTH-1:0]         tgt_addr,
    output logic                          tgt_we,
    output logic [DATA_WIDTH-1:0]         tgt_wrt_data,
    input  logic [NUM_TGT*DATA_WIDTH-1:0] tgt_rd_data,
    input  logic [NUM_TGT-1:0]            tgt_data_valid
);

    // Parameter sanity: at least one target, all targets decodable, nonzero timeout.
    if (NUM_TGT < 1 || NUM_TGT > (1 << SEL_BITS) || TIMEOUT < 1) begin : g_param_err
        $error("soc_bus_fabric: illegal NUM_TGT/SEL_BITS/TIMEOUT combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // One-hot decode of a target select value; values >= NUM_TGT give all zeros.
    function automatic logic [NUM_TGT-1:0] sel_onehot(input logic [SEL_BITS-1:0] sel);
        logic [NUM_TGT-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (sel == SEL_BITS'(i)) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    state_t                  state_q,         state_d;
    logic [SEL_BITS-1:0]     sel_q,           sel_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,       rd_data_d;
    logic                    data_valid_q,    data_valid_d;
    logic                    err_q,           err_d;
    logic [NUM_TGT-1:0]      tgt_req_valid_q, tgt_req_valid_d;
    logic [ADDR_WIDTH-1:0]   tgt_addr_q,      tgt_addr_d;
    logic                    tgt_we_q,        tgt_we_d;
    logic [DATA_WIDTH-1:0]   tgt_wrt_data_q,  tgt_wrt_data_d;

    logic [SEL_BITS-1:0]     addr_sel_s;
    logic                    addr_mapped_s;
    logic                    sel_valid_s;
    logic [DATA_WIDTH-1:0]   sel_rdata_s;

`ifdef BUS_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    // Last cycle count that may still carry a valid response (ISSUE counts as 0).
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]             cnt_q, cnt_d;
`endif

    assign addr_sel_s    = addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign addr_mapped_s = (32'(addr_sel_s) < NUM_TGT);

    // Response mux: strobe and data of the currently selected target only.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_rdata_s = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (sel_q == SEL_BITS'(i)) begin
                sel_valid_s = tgt_data_valid[i];
                sel_rdata_s = tgt_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_valid_s = sel_valid_s;
                sel_rdata_s = sel_rdata_s;
            end
        end
    end

    // Next-state and registered-output logic of the request FSM.
    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        rd_data_d       = rd_data_q;
        data_valid_d    = 1'b0;
        err_d           = 1'b0;
        tgt_req_valid_d = '0;
        tgt_addr_d      = tgt_addr_q;
        tgt_we_d        = tgt_we_q;
        tgt_wrt_data_d  = tgt_wrt_data_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d           = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tgt_addr_d     = addr;
                    tgt_we_d       = we;
                    tgt_wrt_data_d = wrt_data;
                    sel_d          = addr_sel_s;
                    if (addr_mapped_s) begin
                        state_d         = ISSUE;
                        tgt_req_valid_d = sel_onehot(addr_sel_s);
`ifdef BUS_TIMEOUT_EN
                        cnt_d           = '0;
`endif
                    end else begin
                        // Unmapped: answer immediately, no target sees the request.
                        state_d      = IDLE;
                        rd_data_d    = '1;
                        data_valid_d = 1'b1;
                        err_d        = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE, WAIT: begin
                // The selected strobe is honoured already in the ISSUE cycle.
                if (sel_valid_s) begin
                    state_d      = IDLE;
                    rd_data_d    = sel_rdata_s;
                    data_valid_d = 1'b1;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    // Response in the last allowed cycle wins; expiry only without it.
                    if (cnt_q == CNT_LAST) begin
                        state_d      = IDLE;
                        rd_data_d    = '1;
                        data_valid_d = 1'b1;
                        err_d        = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = WAIT;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            sel_q           <= '0;
            rd_data_q       <= '0;
            data_valid_q    <= 1'b0;
            err_q           <= 1'b0;
            tgt_req_valid_q <= '0;
            tgt_addr_q      <= '0;
            tgt_we_q        <= 1'b0;
            tgt_wrt_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            rd_data_q       <= rd_data_d;
            data_valid_q    <= data_valid_d;
            err_q           <= err_d;
            tgt_req_valid_q <= tgt_req_valid_d;
            tgt_addr_q      <= tgt_addr_d;
            tgt_we_q        <= tgt_we_d;
            tgt_wrt_data_q  <= tgt_wrt_data_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Response wait counter; saturates at CNT_LAST because expiry leaves WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign rd_data       = rd_data_q;
    assign data_valid    = data_valid_q;
    assign err           = err_q;
    assign busy          = (state_q != IDLE);
    assign tgt_req_valid = tgt_req_valid_q;
    assign tgt_addr      = tgt_addr_q;
    assign tgt_we        = tgt_we_q;
    assign tgt_wrt_data  = tgt_wrt_data_q;

endmodule
